if_fetch_stage: RTL and testbench

Instruction fetch stage for the 5-stage RV32 pipeline; the producer end of the IF/ID interface that the decode stage consumes (`if_id_IR`, `if_id_PC`, `if_id_valid_inst`). It holds the fetch PC and issues pipelined requests to instruction memory over a valid/ready request channel with an in-order response channel. Responses are buffered in a 2-entry fetch queue and driven into the IF/ID register. The block honours the decode-stage load-use stall and flushes on branch/jump redirects from EX, using an epoch tag to discard stale responses.

---
 rtl/if_fetch_stage.sv | 160 ++++++++++++++++
 tb/tb_if_fetch_stage.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/if_fetch_stage.sv
// RV32 instruction fetch: issues pipelined imem requests, buffers responses in a 2-entry queue, drives IF/ID.
// Latency: accept at t, IF/ID valid at t+2; requests throttle on inflight+queued credit, id_stall holds IF/ID.
module if_fetch_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        id_stall,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_req_addr,
    input  logic        imem_resp_valid,
    input  logic [31:0] imem_resp_data,
    output logic [31:0] if_id_IR,
    output logic [31:0] if_id_PC,
    output logic        if_id_valid_inst
);

    localparam logic [31:0] NOP = 32'h0000_0013;

    typedef struct packed {
        logic [31:0] pc;
        logic        epoch;
    } tag_t;

    typedef struct packed {
        logic [31:0] ir;
        logic [31:0] pc;
    } ent_t;

    logic [31:0] fetch_pc_q, fetch_pc_d;
    logic        epoch_q, epoch_d;
    tag_t        tag_q [2];
    tag_t        tag_d [2];
    logic        tag_head_q, tag_head_d;
    logic [1:0]  inflight_q, inflight_d;
    ent_t        fq_q [2];
    ent_t        fq_d [2];
    logic        fq_head_q, fq_head_d;
    logic [1:0]  qcount_q, qcount_d;
    ent_t        ifid_q, ifid_d;
    logic        ifid_vld_q, ifid_vld_d;

    logic        credit_ok;
    logic        req_vld;
    logic        req_fire;
    logic        resp_pop;
    tag_t        resp_tag;
    ent_t        resp_ent;
    logic        resp_keep;
    logic        resp_bypass;
    logic        resp_enq;
    logic        q_empty;
    logic        deq;
    logic        tag_tail;
    logic        fq_tail;

    // Every outstanding request owns a queue slot, so the queue can never overflow.
    assign credit_ok   = ({1'b0, inflight_q} + {1'b0, qcount_q}) < 3'd2;
    assign req_vld     = rst & ~redirect_valid & credit_ok;
    assign req_fire    = req_vld & imem_req_ready;
    assign resp_pop    = imem_resp_valid & (inflight_q != 2'd0);
    assign resp_tag    = tag_q[tag_head_q];
    assign resp_ent    = '{ir: imem_resp_data, pc: resp_tag.pc};
    assign resp_keep   = resp_pop & (resp_tag.epoch == epoch_q) & ~redirect_valid;
    assign q_empty     = (qcount_q == 2'd0);
    assign resp_bypass = resp_keep & q_empty & ~id_stall;
    assign resp_enq    = resp_keep & ~resp_bypass;
    assign deq         = ~redirect_valid & ~id_stall & ~q_empty;
    assign tag_tail    = tag_head_q ^ inflight_q[0];
    assign fq_tail     = fq_head_q ^ qcount_q[0];

    always_comb begin
        fetch_pc_d = fetch_pc_q;
        epoch_d    = epoch_q;
        tag_d      = tag_q;
        tag_head_d = tag_head_q;
        inflight_d = inflight_q + {1'b0, req_fire} - {1'b0, resp_pop};
        fq_d       = fq_q;
        fq_head_d  = fq_head_q;
        qcount_d   = qcount_q + {1'b0, resp_enq} - {1'b0, deq};
        ifid_d     = ifid_q;
        ifid_vld_d = ifid_vld_q;

        if (req_fire) begin
            tag_d[tag_tail] = '{pc: fetch_pc_q, epoch: epoch_q};
            fetch_pc_d      = fetch_pc_q + 32'd4;
        end
        if (resp_pop) begin
            tag_head_d = ~tag_head_q;
        end
        if (resp_enq) begin
            fq_d[fq_tail] = resp_ent;
        end
        if (deq) begin
            fq_head_d = ~fq_head_q;
        end

        if (redirect_valid) begin
            ifid_d     = '{ir: NOP, pc: 32'd0};
            ifid_vld_d = 1'b0;
        end else if (id_stall) begin
            ifid_d     = ifid_q;
            ifid_vld_d = ifid_vld_q;
        end else if (!q_empty) begin
            ifid_d     = fq_q[fq_head_q];
            ifid_vld_d = 1'b1;
        end else if (resp_bypass) begin
            ifid_d     = resp_ent;
            ifid_vld_d = 1'b1;
        end else begin
            ifid_d     = '{ir: NOP, pc: 32'd0};
            ifid_vld_d = 1'b0;
        end

        // In-flight tags survive a redirect so their responses drain under the old epoch.
        if (redirect_valid) begin
            fetch_pc_d = {redirect_pc[31:2], 2'b00};
            epoch_d    = ~epoch_q;
            qcount_d   = 2'd0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            fetch_pc_q <= RESET_PC;
            epoch_q    <= 1'b0;
            tag_q[0]   <= '0;
            tag_q[1]   <= '0;
            tag_head_q <= 1'b0;
            inflight_q <= 2'd0;
            fq_q[0]    <= '0;
            fq_q[1]    <= '0;
            fq_head_q  <= 1'b0;
            qcount_q   <= 2'd0;
            ifid_q     <= '{ir: NOP, pc: 32'd0};
            ifid_vld_q <= 1'b0;
        end else begin
            fetch_pc_q <= fetch_pc_d;
            epoch_q    <= epoch_d;
            tag_q      <= tag_d;
            tag_head_q <= tag_head_d;
            inflight_q <= inflight_d;
            fq_q       <= fq_d;
            fq_head_q  <= fq_head_d;
            qcount_q   <= qcount_d;
            ifid_q     <= ifid_d;
            ifid_vld_q <= ifid_vld_d;
        end
    end

    assign imem_req_valid   = req_vld;
    assign imem_req_addr    = fetch_pc_q;
    assign if_id_IR         = ifid_q.ir;
    assign if_id_PC         = ifid_q.pc;
    assign if_id_valid_inst = ifid_vld_q;

endmodule

// File: tb/tb_if_fetch_stage.sv
// Directed bench for if_fetch_stage: per-cycle vector table plus a PC wrap-around sequence.
module tb_if_fetch_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        id_stall;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_resp_valid;
    logic [31:0] imem_resp_data;
    logic [31:0] if_id_IR;
    logic [31:0] if_id_PC;
    logic        if_id_valid_inst;

    always #5 clk = ~clk;

    if_fetch_stage #(.RESET_PC(32'h0000_0100)) dut (
        .clk              (clk),
        .rst              (rst),
        .id_stall         (id_stall),
        .redirect_valid   (redirect_valid),
        .redirect_pc      (redirect_pc),
        .imem_req_valid   (imem_req_valid),
        .imem_req_ready   (imem_req_ready),
        .imem_req_addr    (imem_req_addr),
        .imem_resp_valid  (imem_resp_valid),
        .imem_resp_data   (imem_resp_data),
        .if_id_IR         (if_id_IR),
        .if_id_PC         (if_id_PC),
        .if_id_valid_inst (if_id_valid_inst)
    );

    localparam logic [31:0] NOP = 32'h0000_0013;

    int tests = 0;
    int fails = 0;
    int cyc = 0;
    int mem_lat = 1;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return a ^ 32'h5A5A_0000;
    endfunction

    // Fixed-latency in-order instruction memory, cleared whenever rst is low.
    typedef struct {
        logic [31:0] addr;
        int          due;
    } mreq_t;
    mreq_t mq[$];

    initial begin
        imem_resp_valid = 1'b0;
        imem_resp_data  = 32'd0;
        forever begin
            @(negedge clk);
            if (!rst) begin
                mq.delete();
                imem_resp_valid = 1'b0;
                imem_resp_data  = 32'd0;
            end else begin
                if (mq.size() > 0 && mq[0].due <= cyc) begin
                    imem_resp_valid = 1'b1;
                    imem_resp_data  = mem_word(mq[0].addr);
                    mq.delete(0);
                end else begin
                    imem_resp_valid = 1'b0;
                end
                if (imem_req_valid && imem_req_ready)
                    mq.push_back('{addr: imem_req_addr, due: cyc + mem_lat});
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step(input logic r, input logic st, input logic rv, input logic [31:0] rpc,
                        input logic rdy, input int lat);
        @(posedge clk);
        #1;
        rst            = r;
        id_stall       = st;
        redirect_valid = rv;
        redirect_pc    = rpc;
        imem_req_ready = rdy;
        mem_lat        = lat;
        @(negedge clk);
    endtask

    typedef struct {
        logic        rst;
        logic        stall;
        logic        redir;
        logic [31:0] rpc;
        logic        rdy;
        int          lat;
        logic        e_rvld;
        logic [31:0] e_raddr;
        logic        e_vld;
        logic [31:0] e_pc;
    } vec_t;
    vec_t vecs[$];

    task automatic add(input logic r, input logic st, input logic rv, input logic [31:0] rpc,
                       input logic rdy, input int lat, input logic erv, input logic [31:0] era,
                       input logic ev, input logic [31:0] epc);
        vecs.push_back('{rst: r, stall: st, redir: rv, rpc: rpc, rdy: rdy, lat: lat,
                         e_rvld: erv, e_raddr: era, e_vld: ev, e_pc: epc});
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

    initial begin
        //   rst st rd rpc           rdy lat  rvld raddr         vld pc
        add(0, 0, 0, 32'h0,        1, 1,  0, 32'h0,        0, 32'h0);   // 0 reset state
        add(1, 0, 0, 32'h0,        1, 1,  1, 32'h100,      0, 32'h0);   // 1 first request
        add(1, 0, 0, 32'h0,        1, 1,  1, 32'h104,      0, 32'h0);
        add(1, 0, 0, 32'h0,        1, 1,  1, 32'h108,      1, 32'h100);
        add(1, 1, 0, 32'h0,        1, 1,  1, 32'h10C,      1, 32'h104); // 4 stall x3
        add(1, 1, 0, 32'h0,        1, 1,  0, 32'h0,        1, 32'h104);
        add(1, 1, 0, 32'h0,        1, 1,  0, 32'h0,        1, 32'h104);
        add(1, 0, 0, 32'h0,        1, 1,  0, 32'h0,        1, 32'h104);
        add(1, 0, 0, 32'h0,        1, 1,  1, 32'h110,      1, 32'h108);
        add(1, 0, 0, 32'h0,        1, 1,  1, 32'h114,      1, 32'h10C);
        add(1, 0, 0, 32'h0,        0, 1,  1, 32'h118,      1, 32'h110); // 10 ready low x5
        add(1, 0, 0, 32'h0,        0, 1,  1, 32'h118,      1, 32'h114);
        add(1, 0, 0, 32'h0,        0, 1,  1, 32'h118,      0, 32'h0);
        add(1, 0, 0, 32'h0,        0, 1,  1, 32'h118,      0, 32'h0);
        add(1, 0, 0, 32'h0,        0, 1,  1, 32'h118,      0, 32'h0);
        add(1, 0, 0, 32'h0,        1, 1,  1, 32'h118,      0, 32'h0);
        add(1, 0, 0, 32'h0,        1, 1,  1, 32'h11C,      0, 32'h0);
        add(1, 0, 0, 32'h0,        1, 1,  1, 32'h120,      1, 32'h118);
        add(1, 1, 0, 32'h0,        1, 1,  1, 32'h124,      1, 32'h11C); // 18 fill queue
        add(1, 1, 0, 32'h0,        1, 1,  0, 32'h0,        1, 32'h11C);
        add(0, 1, 0, 32'h0,        1, 1,  0, 32'h0,        1, 32'h11C); // 20 reset, queue full
        add(0, 0, 0, 32'h0,        1, 3,  0, 32'h0,        0, 32'h0);
        add(1, 0, 0, 32'h0,        1, 3,  1, 32'h100,      0, 32'h0);
        add(1, 0, 0, 32'h0,        1, 3,  1, 32'h104,      0, 32'h0);
        add(1, 0, 1, 32'h203,      1, 3,  0, 32'h0,        0, 32'h0);   // 24 redirect, 2 in flight
        add(1, 0, 0, 32'h0,        1, 3,  0, 32'h0,        0, 32'h0);
        add(1, 0, 0, 32'h0,        1, 3,  1, 32'h200,      0, 32'h0);
        add(1, 0, 0, 32'h0,        1, 3,  1, 32'h204,      0, 32'h0);
        add(1, 0, 0, 32'h0,        1, 3,  0, 32'h0,        0, 32'h0);
        add(1, 0, 0, 32'h0,        1, 3,  0, 32'h0,        0, 32'h0);
        add(1, 0, 0, 32'h0,        1, 3,  1, 32'h208,      1, 32'h200);
        add(1, 0, 0, 32'h0,        1, 3,  1, 32'h20C,      1, 32'h204);
        add(1, 0, 0, 32'h0,        1, 3,  0, 32'h0,        0, 32'h0);
        add(1, 0, 0, 32'h0,        1, 3,  0, 32'h0,        0, 32'h0);
        add(1, 1, 1, 32'h300,      1, 3,  0, 32'h0,        1, 32'h208); // 34 redirect + stall
        add(1, 1, 0, 32'h0,        1, 3,  1, 32'h300,      0, 32'h0);
        add(1, 0, 0, 32'h0,        1, 3,  1, 32'h304,      0, 32'h0);
        add(1, 0, 0, 32'h0,        1, 3,  0, 32'h0,        0, 32'h0);
        add(1, 0, 0, 32'h0,        1, 3,  0, 32'h0,        0, 32'h0);
        add(1, 0, 0, 32'h0,        1, 3,  1, 32'h308,      1, 32'h300);
        add(1, 0, 0, 32'h0,        1, 3,  1, 32'h30C,      1, 32'h304);

        rst            = 1'b0;
        id_stall       = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = 32'd0;
        imem_req_ready = 1'b1;
        @(posedge clk);

        for (int k = 0; k < vecs.size(); k++) begin
            vec_t v;
            logic [31:0] e_ir;
            v = vecs[k];
            step(v.rst, v.stall, v.redir, v.rpc, v.rdy, v.lat);
            e_ir = v.e_vld ? mem_word(v.e_pc) : NOP;
            chk($sformatf("row%0d req_valid", k), {31'd0, imem_req_valid}, {31'd0, v.e_rvld});
            if (v.e_rvld)
                chk($sformatf("row%0d req_addr", k), imem_req_addr, v.e_raddr);
            chk($sformatf("row%0d valid_inst", k), {31'd0, if_id_valid_inst}, {31'd0, v.e_vld});
            chk($sformatf("row%0d if_id_PC", k), if_id_PC, v.e_pc);
            chk($sformatf("row%0d if_id_IR", k), if_id_IR, e_ir);
        end

        // Redirect to the last word of the address space; fetch must wrap to 0.
        step(0, 0, 0, 32'h0, 1, 1);
        step(1, 0, 1, 32'hFFFF_FFFF, 1, 1);
        chk("wrap redirect req_valid", {31'd0, imem_req_valid}, 32'd0);
        step(1, 0, 0, 32'h0, 1, 1);
        chk("wrap first addr", imem_req_addr, 32'hFFFF_FFFC);
        chk("wrap first req_valid", {31'd0, imem_req_valid}, 32'd1);
        step(1, 0, 0, 32'h0, 1, 1);
        chk("wrap next addr", imem_req_addr, 32'h0000_0000);
        step(1, 0, 0, 32'h0, 1, 1);
        chk("wrap ifid pc top", if_id_PC, 32'hFFFF_FFFC);
        chk("wrap ifid ir top", if_id_IR, mem_word(32'hFFFF_FFFC));
        chk("wrap ifid valid top", {31'd0, if_id_valid_inst}, 32'd1);
        step(1, 0, 0, 32'h0, 1, 1);
        chk("wrap ifid pc zero", if_id_PC, 32'h0000_0000);
        chk("wrap ifid ir zero", if_id_IR, 32'h5A5A_0000);
        chk("wrap ifid valid zero", {31'd0, if_id_valid_inst}, 32'd1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
